wb_master_bridge: RTL

Wishbone classic single-transfer initiator driven by a valid/ready command port and returning a valid/ready response. It is the opposite end of the user-area Wishbone slave port (wbs_*): it lets on-chip logic such as a LA-driven test sequencer or a controller core issue reads and writes to any Wishbone responder, including user_proj_example-style slaves, inside the user area. One transfer is outstanding at a time. An optional bus timeout guarantees forward progress when a slave never acknowledges.

---
 rtl/wb_master_bridge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator: valid/ready command in, valid/ready response out.
// Optional bus timeout is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   bus_ack;
    logic   timeout_hit;

    assign cmd_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign bus_ack     = (state == BUS) && wbm_ack_i;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // The ack has priority, so an ack in the final allowed cycle is never turned into an abort.
    assign timeout_hit = (state == BUS) && !wbm_ack_i &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt    <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            if (accept) begin
                to_cnt <= '0;
            end else if ((state == BUS) && !wbm_ack_i && !timeout_hit) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (bus_ack) begin
                rsp_err_o <= 1'b0;
            end else if (timeout_hit) begin
                rsp_err_o <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_params;

    assign timeout_hit           = 1'b0;
    assign rsp_err_o             = 1'b0;
    assign unused_timeout_params = (TIMEOUT_CYCLES > 0) && (TO_W > 0);
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                if (bus_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus-side request fields keep their last values after cyc drops; only cyc/stb return low.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            rsp_dat_o <= 32'h0;
        end else begin
            if (accept) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
            end
            if (bus_ack) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                rsp_dat_o <= wbm_we_o ? 32'h0 : wbm_dat_i;
            end else if (timeout_hit) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                rsp_dat_o <= 32'h0;
            end
        end
    end

endmodule
